// File: rtl/router_pkg.sv
// Shared definitions for the channel merger and the downstream 4-way router.
package router_pkg;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = $clog2(NUM_CH);
    localparam int PKT_W  = ADDR_W + DATA_W;

    typedef logic [PKT_W-1:0] pkt_t;
endpackage

// File: rtl/rr_arbiter.sv
// Channel arbiter: round-robin from rr_ptr, or fixed priority (channel 0 highest)
// when MERGER_FIXED_PRIO_EN is defined.
module rr_arbiter
    import router_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_CH-1:0]   req,
    input  logic                advance,
    output logic                grant_valid,
    output logic [ADDR_W-1:0]   grant_idx
);

`ifdef MERGER_FIXED_PRIO_EN
    logic unused_ok;
    assign unused_ok = ^{clk_i, rst_ni, advance};

    // Descending scan so the lowest requesting index is the last to win.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_valid = 1'b1;
                grant_idx   = ADDR_W'(i);
            end
        end
    end
`else
    logic [ADDR_W-1:0] rr_ptr;
    logic [ADDR_W-1:0] cand;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= grant_idx + ADDR_W'(1);
        end
    end

    // NUM_CH is a power of two, so the ADDR_W-bit sum wraps modulo NUM_CH.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = rr_ptr + ADDR_W'(k);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end
`endif

endmodule

// File: rtl/channel_merger.sv
// NUM_CH-to-1 merger: arbitrated input channels, source-tagged packets, show-ahead FIFO.
// Build option: MERGER_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module channel_merger
    import router_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_CH-1:0]               valid_i,
    input  logic [NUM_CH-1:0][DATA_W-1:0]   data_i,
    output logic [NUM_CH-1:0]               ready_o,
    output logic                            valid_o,
    output logic [PKT_W-1:0]                data_o,
    input  logic                            ready_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    pkt_t               mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               grant_valid;
    logic [ADDR_W-1:0]  grant_idx;
    logic               full;
    logic               wr_en;
    logic               rd_en;

    rr_arbiter u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req         (valid_i),
        .advance     (wr_en),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Handshakes: a word moves when valid and ready are both high at the rising
    // edge. ready_o is combinational on valid_i, so sources must assert valid
    // without waiting for ready; valid_o/data_o hold until ready_i takes the word.
    // A full FIFO refuses writes even when a read frees a slot in the same cycle.
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign wr_en   = rst_ni && grant_valid && !full;
    assign ready_o = wr_en ? (NUM_CH'(1) << grant_idx) : '0;
    assign valid_o = (count != '0);
    assign rd_en   = valid_o && ready_i;
    assign data_o  = valid_o ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= {grant_idx, data_i[grant_idx]};
        end
    end

endmodule

// File: tb/tb_channel_merger.sv
// Bench for channel_merger: directed scenarios plus random traffic against a queue model.
module tb_channel_merger;
    import router_pkg::*;

    localparam int FIFO_DEPTH = 4;

    logic                           clk = 1'b0;
    logic                           rst_ni = 1'b0;
    logic [NUM_CH-1:0]              valid_i = '0;
    logic [NUM_CH-1:0][DATA_W-1:0]  data_i = '0;
    logic [NUM_CH-1:0]              ready_o;
    logic                           valid_o;
    logic [PKT_W-1:0]               data_o;
    logic                           ready_i = 1'b0;

    channel_merger #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i)
    );

    always #5 clk = ~clk;

    int               n_vec = 0;
    int               n_err = 0;
    logic [PKT_W-1:0] exp_q[$];
    int               acc_log[$];
    int               last_ch = NUM_CH - 1;
    logic             pend_v = 1'b0;
    logic [PKT_W-1:0] pend_pkt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: the first requester after the last served channel,
    // going around the ring; fixed build takes the lowest requester.
    function automatic int pick(input logic [NUM_CH-1:0] v);
`ifdef MERGER_FIXED_PRIO_EN
        for (int i = 0; i < NUM_CH; i++)
            if (v[i]) return i;
`else
        for (int off = 1; off <= NUM_CH; off++) begin
            int ch;
            ch = (last_ch + off) % NUM_CH;
            if (v[ch]) return ch;
        end
`endif
        return -1;
    endfunction

    function automatic logic [NUM_CH-1:0][DATA_W-1:0] rand_data();
        logic [NUM_CH-1:0][DATA_W-1:0] d;
        for (int i = 0; i < NUM_CH; i++) d[i] = DATA_W'($urandom_range(0, 255));
        return d;
    endfunction

    // One clock cycle of stimulus; the write accepted this cycle joins the
    // model queue at the next cycle, matching when it becomes visible.
    task automatic drive(input logic rst, input logic [NUM_CH-1:0] v,
                         input logic [NUM_CH-1:0][DATA_W-1:0] d, input logic rdy);
        int g;
        logic [NUM_CH-1:0] exp_rdy;
        @(negedge clk);
        if (pend_v) begin
            exp_q.push_back(pend_pkt);
            pend_v = 1'b0;
        end
        rst_ni  = rst;
        valid_i = v;
        data_i  = d;
        ready_i = rdy;
        #1;
        if (!rst) begin
            check("ready_in_reset", 32'(ready_o), 32'd0);
            exp_q.delete();
            acc_log.delete();
            last_ch = NUM_CH - 1;
        end else begin
            g = pick(v);
            exp_rdy = '0;
            if (g >= 0 && exp_q.size() < FIFO_DEPTH) exp_rdy[g] = 1'b1;
            check("ready_o", 32'(ready_o), 32'(exp_rdy));
            if (exp_rdy != '0) begin
                pend_v   = 1'b1;
                pend_pkt = {ADDR_W'(g), d[g]};
                acc_log.push_back(g);
                last_ch  = g;
            end
        end
    endtask

    // Monitor: compares the output stream with the head of the model queue.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_ni) begin
                check("valid_o", 32'(valid_o), 32'(exp_q.size() != 0));
                if (valid_o && exp_q.size() != 0) begin
                    check("data_o", 32'(data_o), 32'(exp_q[0]));
                    if (ready_i) void'(exp_q.pop_front());
                end else if (!valid_o) begin
                    check("data_o_idle", 32'(data_o), 32'd0);
                end
            end
        end
    end

    initial begin
        logic [NUM_CH-1:0][DATA_W-1:0] d;
        logic [PKT_W-1:0] hold;
        int exp_ch;

        // Reset with every channel requesting
        drive(1'b0, '1, rand_data(), 1'b0);
        drive(1'b0, '1, rand_data(), 1'b0);
        check("reset_valid_o", 32'(valid_o), 32'd0);
        check("reset_data_o", 32'(data_o), 32'd0);
        drive(1'b1, '1, rand_data(), 1'b0);
        check("first_grant", 32'(ready_o), 32'b0001);

        // Single word from channel 2
        drive(1'b0, '0, '0, 1'b1);
        d = '0;
        d[2] = 8'hA5;
        drive(1'b1, 4'b0100, d, 1'b1);
        drive(1'b1, '0, d, 1'b1);
        check("single_valid", 32'(valid_o), 32'd1);
        check("single_data", 32'(data_o), 32'h2A5);
        drive(1'b1, '0, d, 1'b1);
        check("single_popped", 32'(valid_o), 32'd0);

        // Fairness with all channels requesting
        drive(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 8; i++) drive(1'b1, '1, rand_data(), 1'b1);
        check("fair_count", 32'(acc_log.size()), 32'd8);
        for (int i = 0; i < acc_log.size(); i++) begin
`ifdef MERGER_FIXED_PRIO_EN
            exp_ch = 0;
`else
            exp_ch = i % NUM_CH;
`endif
            check("fair_order", 32'(acc_log[i]), 32'(exp_ch));
        end

        // Fill to full under backpressure, then a single pop
        drive(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b1, '1, rand_data(), 1'b0);
        check("full_ready", 32'(ready_o), 32'd0);
        hold = data_o;
        drive(1'b1, '1, rand_data(), 1'b0);
        check("hold_stable", 32'(data_o), 32'(hold));
        drive(1'b1, '1, rand_data(), 1'b1);
        check("full_no_writethrough", 32'(ready_o), 32'd0);
        drive(1'b1, '1, rand_data(), 1'b0);
        drive(1'b1, '1, rand_data(), 1'b0);

        // Simultaneous read and write at two entries
        drive(1'b0, '0, '0, 1'b0);
        drive(1'b1, 4'b0010, rand_data(), 1'b0);
        drive(1'b1, 4'b1000, rand_data(), 1'b0);
        drive(1'b1, 4'b0001, rand_data(), 1'b1);
        drive(1'b1, '0, rand_data(), 1'b0);
        check("rw_count", 32'(exp_q.size()), 32'd2);
        for (int i = 0; i < 4; i++) drive(1'b1, '0, rand_data(), 1'b1);

        // Reset while three words are queued
        drive(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, '1, rand_data(), 1'b0);
        drive(1'b0, '1, rand_data(), 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, '0, rand_data(), 1'b1);
        check("midreset_empty", 32'(valid_o), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 59) != 0), NUM_CH'($urandom_range(0, 15)),
                  rand_data(), ($urandom_range(0, 2) != 0));
        end

        for (int i = 0; i < 10; i++) drive(1'b1, '0, rand_data(), 1'b1);
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
